// File: rtl/trax_pkg.sv
// trax_pkg
// Shared definitions for the Trax player core turn sequencer:
//   - seq_state_e  : turn sequencer FSM state encoding (IDLE must stay 0)
//   - ERR_*        : err_code values reported by the sequencer
//   - WHITE/BLACK  : encoding of the own-colour input
//   - MAX_ROW/COL  : main table dimensions used by the table engines
//   - ROUND_W      : width of the saturating round counter
//   - is_wait_state: true for states that wait on an engine done pulse
package trax_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_APPLY   = 4'd1,
    ST_AUTO    = 4'd2,
    ST_COMMIT  = 4'd3,
    ST_SHIFT_D = 4'd4,
    ST_SHIFT_R = 4'd5,
    ST_CHOOSE  = 4'd6,
    ST_TX      = 4'd7,
    ST_ERR     = 4'd8
  } seq_state_e;

  // Timeout shares code 00 with "no error"; err distinguishes the two.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_AC_CAP  = 2'b01;
  localparam logic [1:0] ERR_NO_MOVE = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam int MAX_ROW = 16;
  localparam int MAX_COL = 16;

  localparam int ROUND_W = 8;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_APPLY) || (s == ST_AUTO) || (s == ST_COMMIT) ||
           (s == ST_SHIFT_D) || (s == ST_SHIFT_R) || (s == ST_CHOOSE);
  endfunction

endpackage

// File: rtl/trax_edge_pending.sv
// trax_edge_pending
// Rising-edge detector on the transceiver receive-complete level plus a
// one-deep pending slot for moves that arrive while a turn is in progress.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   end_receive  : receive-complete level from the transceiver
//   busy         : sequencer is inside a turn (events must be queued)
//   take         : sequencer is starting a turn from IDLE this cycle
//   rx_evt       : one-cycle event, high the cycle after end_receive rises
//   pending      : a queued event is waiting for IDLE
//   overrun      : an event arrived while the pending slot was already full
module trax_edge_pending (
  input  logic clk,
  input  logic reset,
  input  logic end_receive,
  input  logic busy,
  input  logic take,
  output logic rx_evt,
  output logic pending,
  output logic overrun
);

  logic [1:0] hist_q, hist_d;
  logic       pending_q, pending_d;

  always_comb begin
    hist_d    = {hist_q[0], end_receive};
    rx_evt    = hist_q[0] & ~hist_q[1];
    overrun   = rx_evt & busy & pending_q;
    pending_d = pending_q;
    // When IDLE consumes the slot in the same cycle a fresh event lands,
    // the fresh event takes the slot instead of being lost.
    if (take) begin
      pending_d = pending_q & rx_evt;
    end else if (rx_evt && busy) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= 2'b00;
      pending_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/trax_turn_sequencer.sv
// trax_turn_sequencer
// Central phase controller for the Trax player core. On each received move
// it drives the table engines strictly in order, one start/done handshake at
// a time: apply move, auto-complete until stable, commit, shift, choose own
// move, then the same chain for the own move, and finally transmit. When this
// player is white the very first event runs the opening half-turn instead
// (choose, then transmit).
// Optional build macro: TRAX_SEQ_TIMEOUT_EN adds a per-phase watchdog of
// TIMEOUT_CYCLES cycles that forces ERR with err_code 00.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   end_receive                : receive-complete level (rise = move received)
//   color                      : own colour, 0 white / 1 black (first event)
//   upd_start/done, upd_own    : apply-move engine, upd_own selects own move
//   ac_start/done, ac_changed  : auto-complete pass handshake
//   cm_start/done, cm_grow_*   : commit engine and its grow flags
//   sd_start/done, sr_start/done : shift-down / shift-right engines
//   ch_start/done, ch_none     : move chooser, ch_none = no legal move
//   opening                    : white opening half-turn in progress
//   tx_start                   : one-cycle pulse to transmit the chosen move
//   busy, err, err_code        : status (err sticky until reset)
module trax_turn_sequencer
  import trax_pkg::*;
#(
  parameter int AC_MAX_PASSES  = 8,
  parameter int PASS_W         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       end_receive,
  input  logic       color,
  output logic       upd_start,
  input  logic       upd_done,
  output logic       upd_own,
  output logic       ac_start,
  input  logic       ac_done,
  input  logic       ac_changed,
  output logic       cm_start,
  input  logic       cm_done,
  input  logic       cm_grow_top,
  input  logic       cm_grow_left,
  output logic       sd_start,
  input  logic       sd_done,
  output logic       sr_start,
  input  logic       sr_done,
  output logic       ch_start,
  input  logic       ch_done,
  input  logic       ch_none,
  output logic       opening,
  output logic       tx_start,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  // Elaboration-time sanity checks; these blocks only exist for bad configs.
  if ((2 ** PASS_W) <= AC_MAX_PASSES) begin : g_bad_pass_w
    $error("trax_turn_sequencer: PASS_W too narrow for AC_MAX_PASSES");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("trax_turn_sequencer: TIMEOUT_CYCLES must be positive");
  end

  seq_state_e          state_q, state_d;
  logic                half_q, half_d;
  logic                opening_q, opening_d;
  logic                upd_own_q, upd_own_d;
  logic                grow_left_q, grow_left_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic                upd_start_q, upd_start_d;
  logic                ac_start_q, ac_start_d;
  logic                cm_start_q, cm_start_d;
  logic                sd_start_q, sd_start_d;
  logic                sr_start_q, sr_start_d;
  logic                ch_start_q, ch_start_d;
  logic                tx_start_q, tx_start_d;

  logic rx_evt;
  logic pending;
  logic overrun;
  logic take;
  logic post_commit;
  logic to_hit;

  trax_edge_pending u_edge (
    .clk         (clk),
    .reset       (reset),
    .end_receive (end_receive),
    .busy        (busy_q),
    .take        (take),
    .rx_evt      (rx_evt),
    .pending     (pending),
    .overrun     (overrun)
  );

`ifdef TRAX_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = is_wait_state(state_q) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  // Restart the watchdog on every state change; count only while waiting.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (is_wait_state(state_q)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    opening_d   = opening_q;
    upd_own_d   = upd_own_q;
    grow_left_d = grow_left_q;
    err_code_d  = err_code_q;
    pass_d      = pass_q;
    round_d     = round_q;
    upd_start_d = 1'b0;
    ac_start_d  = 1'b0;
    cm_start_d  = 1'b0;
    sd_start_d  = 1'b0;
    sr_start_d  = 1'b0;
    ch_start_d  = 1'b0;
    tx_start_d  = 1'b0;
    take        = 1'b0;
    post_commit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_evt || pending) begin
          take    = 1'b1;
          round_d = (round_q == '1) ? round_q : round_q + ROUND_W'(1);
          // Colour only matters on the very first event of the game.
          if ((round_q == '0) && (color == WHITE)) begin
            opening_d  = 1'b1;
            half_d     = 1'b1;
            state_d    = ST_CHOOSE;
            ch_start_d = 1'b1;
          end else begin
            half_d      = 1'b0;
            upd_own_d   = 1'b0;
            state_d     = ST_APPLY;
            upd_start_d = 1'b1;
          end
        end
      end

      ST_APPLY: begin
        if (upd_done) begin
          pass_d     = '0;
          state_d    = ST_AUTO;
          ac_start_d = 1'b1;
        end
      end

      ST_AUTO: begin
        if (ac_done) begin
          if (!ac_changed) begin
            state_d    = ST_COMMIT;
            cm_start_d = 1'b1;
          end else if ((int'(pass_q) + 1) < AC_MAX_PASSES) begin
            pass_d     = pass_q + PASS_W'(1);
            ac_start_d = 1'b1;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_AC_CAP;
          end
        end
      end

      // grow_top is acted on immediately; only grow_left must survive the
      // shift-down phase.
      ST_COMMIT: begin
        if (cm_done) begin
          grow_left_d = cm_grow_left;
          if (cm_grow_top) begin
            state_d    = ST_SHIFT_D;
            sd_start_d = 1'b1;
          end else if (cm_grow_left) begin
            state_d    = ST_SHIFT_R;
            sr_start_d = 1'b1;
          end else begin
            post_commit = 1'b1;
          end
        end
      end

      ST_SHIFT_D: begin
        if (sd_done) begin
          if (grow_left_q) begin
            state_d    = ST_SHIFT_R;
            sr_start_d = 1'b1;
          end else begin
            post_commit = 1'b1;
          end
        end
      end

      ST_SHIFT_R: begin
        if (sr_done) begin
          post_commit = 1'b1;
        end
      end

      // The opening tile is placed by the engines themselves, so the
      // opening skips straight from choose to transmit.
      ST_CHOOSE: begin
        if (ch_done) begin
          if (ch_none) begin
            state_d    = ST_ERR;
            err_code_d = ERR_NO_MOVE;
          end else if (opening_q) begin
            state_d    = ST_TX;
            tx_start_d = 1'b1;
          end else begin
            half_d      = 1'b1;
            upd_own_d   = 1'b1;
            state_d     = ST_APPLY;
            upd_start_d = 1'b1;
          end
        end
      end

      ST_TX: begin
        opening_d = 1'b0;
        upd_own_d = 1'b0;
        state_d   = ST_IDLE;
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // After the commit chain, the opponent half continues with our own
    // move choice; the own half ends with transmission.
    if (post_commit) begin
      if (half_q) begin
        state_d    = ST_TX;
        tx_start_d = 1'b1;
      end else begin
        state_d    = ST_CHOOSE;
        ch_start_d = 1'b1;
      end
    end

    if (to_hit) begin
      state_d    = ST_ERR;
      err_code_d = ERR_TIMEOUT;
    end

    // Overrun has the final word: a third move cannot be queued.
    if (overrun) begin
      state_d    = ST_ERR;
      err_code_d = ERR_OVERRUN;
    end

    if (state_d == ST_ERR) begin
      upd_start_d = 1'b0;
      ac_start_d  = 1'b0;
      cm_start_d  = 1'b0;
      sd_start_d  = 1'b0;
      sr_start_d  = 1'b0;
      ch_start_d  = 1'b0;
      tx_start_d  = 1'b0;
    end

    err_d  = err_q | (state_d == ST_ERR);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      opening_q   <= 1'b0;
      upd_own_q   <= 1'b0;
      grow_left_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
      pass_q      <= '0;
      round_q     <= '0;
      upd_start_q <= 1'b0;
      ac_start_q  <= 1'b0;
      cm_start_q  <= 1'b0;
      sd_start_q  <= 1'b0;
      sr_start_q  <= 1'b0;
      ch_start_q  <= 1'b0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      opening_q   <= opening_d;
      upd_own_q   <= upd_own_d;
      grow_left_q <= grow_left_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      err_code_q  <= err_code_d;
      pass_q      <= pass_d;
      round_q     <= round_d;
      upd_start_q <= upd_start_d;
      ac_start_q  <= ac_start_d;
      cm_start_q  <= cm_start_d;
      sd_start_q  <= sd_start_d;
      sr_start_q  <= sr_start_d;
      ch_start_q  <= ch_start_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign upd_start = upd_start_q;
  assign upd_own   = upd_own_q;
  assign ac_start  = ac_start_q;
  assign cm_start  = cm_start_q;
  assign sd_start  = sd_start_q;
  assign sr_start  = sr_start_q;
  assign ch_start  = ch_start_q;
  assign tx_start  = tx_start_q;
  assign opening   = opening_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// tb_trax_turn_sequencer
// Directed bench for trax_turn_sequencer. A second instance with
// AC_MAX_PASSES=3 shares all inputs and is only checked for the
// auto-complete cap error.
module tb_trax_turn_sequencer;

  localparam int UPD = 0;
  localparam int AC  = 1;
  localparam int CM  = 2;
  localparam int SD  = 3;
  localparam int SR  = 4;
  localparam int CH  = 5;
  localparam int TX  = 6;

  logic clk, reset, end_receive, color;
  logic upd_start, upd_done, upd_own;
  logic ac_start, ac_done, ac_changed;
  logic cm_start, cm_done, cm_grow_top, cm_grow_left;
  logic sd_start, sd_done, sr_start, sr_done;
  logic ch_start, ch_done, ch_none;
  logic opening, tx_start, busy, err;
  logic [1:0] err_code;

  logic cap_upd_start, cap_upd_own, cap_ac_start, cap_cm_start;
  logic cap_sd_start, cap_sr_start, cap_ch_start, cap_opening;
  logic cap_tx_start, cap_busy, cap_err;
  logic [1:0] cap_err_code;

  int vec_count   = 0;
  int miscompares = 0;

  trax_turn_sequencer dut (
    .clk(clk), .reset(reset), .end_receive(end_receive), .color(color),
    .upd_start(upd_start), .upd_done(upd_done), .upd_own(upd_own),
    .ac_start(ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
    .cm_start(cm_start), .cm_done(cm_done),
    .cm_grow_top(cm_grow_top), .cm_grow_left(cm_grow_left),
    .sd_start(sd_start), .sd_done(sd_done),
    .sr_start(sr_start), .sr_done(sr_done),
    .ch_start(ch_start), .ch_done(ch_done), .ch_none(ch_none),
    .opening(opening), .tx_start(tx_start), .busy(busy),
    .err(err), .err_code(err_code)
  );

  trax_turn_sequencer #(.AC_MAX_PASSES(3), .PASS_W(4)) dut_cap (
    .clk(clk), .reset(reset), .end_receive(end_receive), .color(color),
    .upd_start(cap_upd_start), .upd_done(upd_done), .upd_own(cap_upd_own),
    .ac_start(cap_ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
    .cm_start(cap_cm_start), .cm_done(cm_done),
    .cm_grow_top(cm_grow_top), .cm_grow_left(cm_grow_left),
    .sd_start(cap_sd_start), .sd_done(sd_done),
    .sr_start(cap_sr_start), .sr_done(sr_done),
    .ch_start(cap_ch_start), .ch_done(ch_done), .ch_none(ch_none),
    .opening(cap_opening), .tx_start(cap_tx_start), .busy(cap_busy),
    .err(cap_err), .err_code(cap_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] starts_now();
    return {tx_start, ch_start, sr_start, sd_start, cm_start, ac_start, upd_start};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vec_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    upd_done = 0; ac_done = 0; ac_changed = 0; cm_done = 0;
    cm_grow_top = 0; cm_grow_left = 0; sd_done = 0; sr_done = 0;
    ch_done = 0; ch_none = 0;
  endtask

  task automatic doReset();
    reset = 1; end_receive = 0; clearInputs();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  // Produce one rising edge on end_receive.
  task automatic applyStimulus();
    end_receive = 0;
    @(negedge clk);
    end_receive = 1;
    @(negedge clk);
  endtask

  // Wait (bounded) for the next start pulse and require it to be exactly idx.
  task automatic expectStart(input string tag, input int idx);
    int n;
    n = 0;
    while (starts_now() == 7'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 8'(starts_now()), 8'(1 << idx));
  endtask

  task automatic pulseDone(input int idx);
    case (idx)
      UPD:     upd_done = 1;
      AC:      ac_done  = 1;
      CM:      cm_done  = 1;
      SD:      sd_done  = 1;
      SR:      sr_done  = 1;
      CH:      ch_done  = 1;
      default: upd_done = 0;
    endcase
    @(negedge clk);
    clearInputs();
  endtask

  task automatic checkQuiet(input string tag, input int cycles);
    logic [6:0] seen;
    seen = 7'd0;
    repeat (cycles) begin
      @(negedge clk);
      seen |= starts_now();
    end
    checkOutput({tag, " no starts"}, 8'(seen), 8'd0);
    checkOutput({tag, " busy low"}, 8'(busy), 8'd0);
  endtask

  // Full turn after a received move, all grow flags and changed flags 0.
  task automatic runPlainTurn(input string tag);
    expectStart({tag, " upd rx"}, UPD);
    checkOutput({tag, " upd_own rx"}, 8'(upd_own), 8'd0);
    checkOutput({tag, " opening"}, 8'(opening), 8'd0);
    pulseDone(UPD);
    expectStart({tag, " ac rx"}, AC);  pulseDone(AC);
    expectStart({tag, " cm rx"}, CM);  pulseDone(CM);
    expectStart({tag, " ch"}, CH);     pulseDone(CH);
    expectStart({tag, " upd own"}, UPD);
    checkOutput({tag, " upd_own own"}, 8'(upd_own), 8'd1);
    pulseDone(UPD);
    expectStart({tag, " ac own"}, AC); pulseDone(AC);
    expectStart({tag, " cm own"}, CM); pulseDone(CM);
    expectStart({tag, " tx"}, TX);
    checkOutput({tag, " busy in tx"}, 8'(busy), 8'd1);
    checkQuiet(tag, 6);
  endtask

  initial begin
    reset = 1; end_receive = 0; color = 1; clearInputs();
    repeat (3) @(negedge clk);
    checkOutput("reset starts", 8'(starts_now()), 8'd0);
    checkOutput("reset status", 8'({upd_own, opening, busy, err, err_code}), 8'd0);
    reset = 0;
    @(negedge clk);

    $display("[TB] black turn");
    color = 1;
    applyStimulus();
    runPlainTurn("black");

    $display("[TB] white opening");
    doReset();
    color = 0;
    applyStimulus();
    expectStart("white ch first", CH);
    checkOutput("white opening high", 8'(opening), 8'd1);
    pulseDone(CH);
    expectStart("white tx", TX);
    checkOutput("white opening in tx", 8'(opening), 8'd1);
    @(negedge clk);
    checkOutput("white opening cleared", 8'(opening), 8'd0);
    checkOutput("white busy after tx", 8'(busy), 8'd0);
    applyStimulus();
    runPlainTurn("white t2");

    $display("[TB] auto-complete loop");
    doReset();
    color = 1;
    applyStimulus();
    expectStart("acl upd", UPD);
    pulseDone(UPD);
    for (int p = 0; p < 3; p++) begin
      expectStart("acl changed pass", AC);
      ac_changed = 1;
      pulseDone(AC);
    end
    checkOutput("cap err", 8'(cap_err), 8'd1);
    checkOutput("cap err_code", 8'(cap_err_code), 8'd1);
    checkOutput("cap busy", 8'(cap_busy), 8'd0);
    expectStart("acl 4th pass", AC);
    pulseDone(AC);
    expectStart("acl cm", CM);
    checkOutput("acl main no err", 8'({err, err_code}), 8'd0);

    $display("[TB] grow flags and pending");
    doReset();
    applyStimulus();
    expectStart("grow upd", UPD); pulseDone(UPD);
    expectStart("grow ac", AC);   pulseDone(AC);
    expectStart("grow cm", CM);
    cm_grow_top = 1; cm_grow_left = 1;
    pulseDone(CM);
    expectStart("grow sd", SD);
    applyStimulus();
    pulseDone(SD);
    expectStart("grow sr after sd", SR); pulseDone(SR);
    expectStart("grow ch", CH);          pulseDone(CH);
    expectStart("grow upd own", UPD);    pulseDone(UPD);
    expectStart("grow ac own", AC);      pulseDone(AC);
    expectStart("grow cm own", CM);
    cm_grow_left = 1;
    pulseDone(CM);
    expectStart("grow sr left only", SR); pulseDone(SR);
    expectStart("grow tx", TX);
    @(negedge clk);
    checkOutput("pending idle busy", 8'(busy), 8'd0);
    expectStart("pending consumed", UPD);
    checkOutput("pending upd_own", 8'(upd_own), 8'd0);

    $display("[TB] overrun");
    doReset();
    applyStimulus();
    expectStart("ovr upd", UPD);
    applyStimulus();
    applyStimulus();
    @(negedge clk);
    checkOutput("ovr err", 8'(err), 8'd1);
    checkOutput("ovr err_code", 8'(err_code), 8'd3);
    checkOutput("ovr busy", 8'(busy), 8'd0);
    pulseDone(UPD);
    checkQuiet("ovr hold", 5);
    checkOutput("ovr err sticky", 8'({err, err_code}), 8'h7);

    $display("[TB] no move");
    doReset();
    applyStimulus();
    expectStart("nm upd", UPD); pulseDone(UPD);
    expectStart("nm ac", AC);   pulseDone(AC);
    expectStart("nm cm", CM);   pulseDone(CM);
    expectStart("nm ch", CH);
    ch_none = 1;
    pulseDone(CH);
    checkOutput("nm err", 8'({err, err_code}), 8'h6);
    checkOutput("nm starts", 8'(starts_now()), 8'd0);
    checkOutput("nm busy", 8'(busy), 8'd0);

    $display("[TB] reset during auto");
    doReset();
    applyStimulus();
    expectStart("rst upd", UPD); pulseDone(UPD);
    expectStart("rst ac", AC);
    end_receive = 0;
    reset = 1;
    @(negedge clk);
    checkOutput("rst starts", 8'(starts_now()), 8'd0);
    checkOutput("rst status", 8'({upd_own, opening, busy, err, err_code}), 8'd0);
    reset = 0;
    checkQuiet("rst after", 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
